// File: rtl/cache_arbiter.sv
// cache_arbiter: two-to-one L1 I/D line-request arbiter onto the shared L2; define ARB_RR_EN for round-robin grant instead of fixed D priority
module cache_arbiter #(
  parameter int ADDR_W = 16,
  parameter int LINE_W = 128
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_mem_read,
  input  logic              i_mem_write,
  input  logic [ADDR_W-1:0] i_mem_address,
  input  logic [LINE_W-1:0] i_mem_wdata,
  output logic              i_mem_resp,
  output logic [LINE_W-1:0] i_mem_rdata,
  input  logic              d_mem_read,
  input  logic              d_mem_write,
  input  logic [ADDR_W-1:0] d_mem_address,
  input  logic [LINE_W-1:0] d_mem_wdata,
  output logic              d_mem_resp,
  output logic [LINE_W-1:0] d_mem_rdata,
  input  logic              l2_mem_resp,
  input  logic [LINE_W-1:0] l2_mem_rdata,
  output logic              l2_mem_read,
  output logic              l2_mem_write,
  output logic [ADDR_W-1:0] l2_mem_address,
  output logic [LINE_W-1:0] l2_mem_wdata
);
  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} state_t;
`ifdef ARB_RR_EN
  localparam logic rr_en = 1'b1;
`else
  localparam logic rr_en = 1'b0;
`endif
  state_t state;
  logic last_d;
  logic i_req, d_req, pick_d, w_rd, w_wr;
  logic [ADDR_W-1:0] w_addr;
  logic [LINE_W-1:0] w_wdata;
  always_comb begin
    i_req = i_mem_read | i_mem_write;
    d_req = d_mem_read | d_mem_write;
    pick_d = d_req & (~i_req | ~rr_en | ~last_d);
    w_rd = pick_d ? d_mem_read & ~d_mem_write : i_mem_read & ~i_mem_write;
    w_wr = pick_d ? d_mem_write : i_mem_write;
    w_addr = pick_d ? d_mem_address : i_mem_address;
    w_wdata = pick_d ? d_mem_wdata : i_mem_wdata;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      last_d <= 1'b0;
      l2_mem_read <= 1'b0;
      l2_mem_write <= 1'b0;
      l2_mem_address <= '0;
      l2_mem_wdata <= '0;
    end else if (state == IDLE) begin
      if (i_req | d_req) begin
        state <= pick_d ? SERVE_D : SERVE_I;
        l2_mem_read <= w_rd;
        l2_mem_write <= w_wr;
        l2_mem_address <= w_addr;
        l2_mem_wdata <= w_wdata;
      end
    end else if (l2_mem_resp) begin
      state <= IDLE;
      last_d <= state == SERVE_D;
      l2_mem_read <= 1'b0;
      l2_mem_write <= 1'b0;
    end
  end
  assign i_mem_resp = (state == SERVE_I) & l2_mem_resp;
  assign d_mem_resp = (state == SERVE_D) & l2_mem_resp;
  assign i_mem_rdata = l2_mem_rdata;
  assign d_mem_rdata = l2_mem_rdata;
endmodule

// File: tb/tb_cache_arbiter.sv
// tb_cache_arbiter: directed and random checks of cache_arbiter against a transaction-level reference model
module tb_cache_arbiter;
  logic clk = 1'b0;
  logic reset;
  logic i_mem_read, i_mem_write, i_mem_resp;
  logic [15:0] i_mem_address;
  logic [127:0] i_mem_wdata, i_mem_rdata;
  logic d_mem_read, d_mem_write, d_mem_resp;
  logic [15:0] d_mem_address;
  logic [127:0] d_mem_wdata, d_mem_rdata;
  logic l2_mem_resp, l2_mem_read, l2_mem_write;
  logic [127:0] l2_mem_rdata, l2_mem_wdata;
  logic [15:0] l2_mem_address;
  int n_tests = 0;
  int n_fail = 0;
  int m_own;
  int m_last;
  bit m_rd, m_wr;
  logic [15:0] m_addr;
  logic [127:0] m_wdata;
  bit got_i, got_d;
  always #5 clk = ~clk;
  cache_arbiter dut (
    .clk(clk), .reset(reset),
    .i_mem_read(i_mem_read), .i_mem_write(i_mem_write), .i_mem_address(i_mem_address),
    .i_mem_wdata(i_mem_wdata), .i_mem_resp(i_mem_resp), .i_mem_rdata(i_mem_rdata),
    .d_mem_read(d_mem_read), .d_mem_write(d_mem_write), .d_mem_address(d_mem_address),
    .d_mem_wdata(d_mem_wdata), .d_mem_resp(d_mem_resp), .d_mem_rdata(d_mem_rdata),
    .l2_mem_resp(l2_mem_resp), .l2_mem_rdata(l2_mem_rdata), .l2_mem_read(l2_mem_read),
    .l2_mem_write(l2_mem_write), .l2_mem_address(l2_mem_address), .l2_mem_wdata(l2_mem_wdata)
  );
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic cyc();
    bit i_req, d_req, take_d, rd, wr;
    #4;
    got_i = (m_own == 1) && l2_mem_resp;
    got_d = (m_own == 2) && l2_mem_resp;
    chk("i_resp", i_mem_resp, got_i);
    chk("d_resp", d_mem_resp, got_d);
    chk("l2_read", l2_mem_read, m_rd);
    chk("l2_write", l2_mem_write, m_wr);
    chk("l2_addr", l2_mem_address, m_addr);
    chk("l2_wdata", l2_mem_wdata, m_wdata);
    if (got_i) chk("i_rdata", i_mem_rdata, l2_mem_rdata);
    if (got_d) chk("d_rdata", d_mem_rdata, l2_mem_rdata);
    i_req = i_mem_read || i_mem_write;
    d_req = d_mem_read || d_mem_write;
    if (reset) begin
      m_own = 0; m_last = 1; m_rd = 0; m_wr = 0; m_addr = 0; m_wdata = 0;
      got_i = 0; got_d = 0;
    end else if (m_own == 0) begin
      if (i_req || d_req) begin
`ifdef ARB_RR_EN
        take_d = d_req && (!i_req || m_last == 1);
`else
        take_d = d_req;
`endif
        rd = take_d ? d_mem_read : i_mem_read;
        wr = take_d ? d_mem_write : i_mem_write;
        m_own = take_d ? 2 : 1;
        m_wr = wr;
        m_rd = rd && !wr;
        m_addr = take_d ? d_mem_address : i_mem_address;
        m_wdata = take_d ? d_mem_wdata : i_mem_wdata;
      end
    end else if (l2_mem_resp) begin
      m_last = m_own; m_own = 0; m_rd = 0; m_wr = 0;
    end
    @(posedge clk);
    #1;
  endtask
  initial begin
    reset = 1; i_mem_read = 0; i_mem_write = 0; i_mem_address = 0; i_mem_wdata = 0;
    d_mem_read = 0; d_mem_write = 0; d_mem_address = 0; d_mem_wdata = 0;
    l2_mem_resp = 0; l2_mem_rdata = 0;
    m_own = 0; m_last = 1; m_rd = 0; m_wr = 0; m_addr = 0; m_wdata = 0;
    @(posedge clk);
    #1;
    cyc();
    reset = 0;
    cyc();
    // single I read, response three cycles after the strobe starts
    i_mem_read = 1; i_mem_address = 16'h3A40;
    cyc();
    chk("t1_read", l2_mem_read, 1'b1);
    chk("t1_addr", l2_mem_address, 16'h3A40);
    cyc(); cyc(); cyc();
    l2_mem_resp = 1; l2_mem_rdata = 128'hDEAD_BEEF;
    cyc();
    l2_mem_resp = 0; i_mem_read = 0;
    cyc();
    // single D write; wdata changes after capture must not leak through
    d_mem_write = 1; d_mem_address = 16'h1230; d_mem_wdata = 128'h0123_4567;
    cyc();
    d_mem_wdata = 128'hFFFF_0000;
    cyc();
    chk("t2_wdata", l2_mem_wdata, 128'h0123_4567);
    l2_mem_resp = 1;
    cyc();
    l2_mem_resp = 0; d_mem_write = 0;
    cyc();
    // simultaneous requests, D re-requests right away
    i_mem_read = 1; i_mem_address = 16'h0100;
    d_mem_read = 1; d_mem_address = 16'h0200;
    cyc(); cyc();
    l2_mem_resp = 1;
    cyc();
    l2_mem_resp = 0; d_mem_address = 16'h0300;
    cyc(); cyc();
    l2_mem_resp = 1;
    cyc();
    l2_mem_resp = 0; d_mem_read = 0;
    cyc(); cyc();
    l2_mem_resp = 1;
    cyc();
    l2_mem_resp = 0; i_mem_read = 0;
    // reset while D is being served
    d_mem_read = 1; d_mem_address = 16'h4440;
    cyc(); cyc();
    reset = 1; d_mem_read = 0;
    cyc();
    reset = 0; l2_mem_resp = 1;
    cyc();
    chk("t5_read", l2_mem_read, 1'b0);
    // spurious response in IDLE
    cyc();
    l2_mem_resp = 0;
    // read and write together on D
    d_mem_read = 1; d_mem_write = 1; d_mem_address = 16'h5550; d_mem_wdata = 128'h77;
    cyc(); cyc();
    l2_mem_resp = 1;
    cyc();
    l2_mem_resp = 0; d_mem_read = 0; d_mem_write = 0;
    cyc();
    // random traffic
    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom_range(0, 59) == 0);
      if (!(i_mem_read || i_mem_write) && $urandom_range(0, 2) == 0) begin
        {i_mem_read, i_mem_write} = 2'($urandom_range(1, 3));
        i_mem_address = 16'($urandom);
        i_mem_wdata = {4{$urandom}};
      end else if (m_own == 1 && $urandom_range(0, 3) == 0)
        i_mem_wdata = {4{$urandom}};
      if (!(d_mem_read || d_mem_write) && $urandom_range(0, 2) == 0) begin
        {d_mem_read, d_mem_write} = 2'($urandom_range(1, 3));
        d_mem_address = 16'($urandom);
        d_mem_wdata = {4{$urandom}};
      end else if (m_own == 2 && $urandom_range(0, 3) == 0)
        d_mem_address = 16'($urandom);
      l2_mem_resp = ($urandom_range(0, 2) == 0);
      l2_mem_rdata = {4{$urandom}};
      cyc();
      if (got_i) begin i_mem_read = 0; i_mem_write = 0; end
      if (got_d) begin d_mem_read = 0; d_mem_write = 0; end
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
